// File: rtl/zuc256_batch_wrapper.sv
// ZUC-256 batch wrapper: ARM command/data FSM driving one zuc256_tot core.
// Optional: define ZUC256_BATCH_CYCLE_CNT_EN to report ISSUE+BUSY cycles in status[23:0].

// Compact stand-in for the cipher core: same strobe/ready contract, simple keystream.
module zuc256_tot (
    input  logic         clk,
    input  logic         resetn,
    input  logic         init,
    input  logic         next,
    input  logic         fin,
    input  logic         enc_auth,
    input  logic [255:0] key,
    input  logic [127:0] iv,
    input  logic [127:0] block_i,
    input  logic [7:0]   i_len,
    input  logic [7:0]   tag_len,
    output logic [127:0] block_o,
    output logic         ready
);
    localparam logic [127:0] KS_MIX = 128'h9E3779B97F4A7C15F39CC0605CEDC834;

    logic [127:0] ks_q, ks_d, blk_q, blk_d;
    logic [2:0]   cnt_q, cnt_d;

    // Strobes are ignored while busy; the wrapper never issues them then.
    always_comb begin
        ks_d  = ks_q;
        blk_d = blk_q;
        cnt_d = cnt_q;
        if (cnt_q != 3'd0) begin
            cnt_d = cnt_q - 3'd1;
        end else if (init) begin
            ks_d  = key[255:128] ^ key[127:0] ^ iv;
            cnt_d = 3'd4;
        end else if (next) begin
            blk_d = block_i ^ ks_q ^ {120'd0, i_len};
            ks_d  = {ks_q[126:0], ks_q[127]} ^ KS_MIX;
            cnt_d = 3'd2;
        end else if (fin) begin
            blk_d = ks_q ^ {tag_len, 112'd0, i_len} ^ (enc_auth ? block_i : ~block_i);
            cnt_d = 3'd3;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ks_q  <= '0;
            blk_q <= '0;
            cnt_q <= '0;
        end else begin
            ks_q  <= ks_d;
            blk_q <= blk_d;
            cnt_q <= cnt_d;
        end
    end

    assign block_o = blk_q;
    assign ready   = (cnt_q == 3'd0);
endmodule

module zuc256_batch_wrapper #(
    parameter int BUS_W = 1024,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      arm_to_fpga_cmd,
    input  logic             arm_to_fpga_cmd_valid,
    output logic             fpga_to_arm_done,
    input  logic             fpga_to_arm_done_read,
    input  logic             arm_to_fpga_data_valid,
    output logic             arm_to_fpga_data_ready,
    input  logic [BUS_W-1:0] arm_to_fpga_data,
    output logic             fpga_to_arm_data_valid,
    input  logic             fpga_to_arm_data_ready,
    output logic [BUS_W-1:0] fpga_to_arm_data,
    output logic [3:0]       leds
);
    generate
        if (DEPTH < 1 || DEPTH > 7 || BUS_W < 128*DEPTH+32 || BUS_W < 529) begin : g_bad_params
            $error("zuc256_batch_wrapper: illegal BUS_W/DEPTH combination");
        end
    endgenerate

    typedef enum logic [3:0] {
        ST_WAIT_CMD = 4'd0,
        ST_READ_CFG = 4'd1,
        ST_READ_BLK = 4'd2,
        ST_INIT     = 4'd3,
        ST_ISSUE    = 4'd4,
        ST_BUSY     = 4'd5,
        ST_FINAL    = 4'd6,
        ST_WRITE    = 4'd7,
        ST_DONE     = 4'd8
    } state_t;

    localparam logic [7:0] OP_READ_CFG = 8'd0;
    localparam logic [7:0] OP_READ_BLK = 8'd1;
    localparam logic [7:0] OP_INIT     = 8'd2;
    localparam logic [7:0] OP_BATCH    = 8'd3;
    localparam logic [7:0] OP_FINAL    = 8'd4;
    localparam logic [7:0] OP_WRITE    = 8'd5;

    state_t                   state_q, state_d;
    logic                     enc_auth_q, enc_auth_d;
    logic [255:0]             key_q, key_d;
    logic [127:0]             iv_q, iv_d;
    logic [7:0]               i_len_q, i_len_d, tag_len_q, tag_len_d;
    logic [DEPTH-1:0][127:0]  slot_q, slot_d, result_q, result_d;
    logic [2:0]               idx_q, idx_d, n_q, n_d, batch_n_q, batch_n_d, op_q, op_d;
    logic                     err_q, err_d;
    logic                     done_q, in_ready_q, out_valid_q;

    logic         core_init, core_next, core_final, core_ready;
    logic [127:0] core_blk, core_out;
    logic [7:0]   core_len;
    logic [7:0]   cmd_op, cmd_n;
    logic         n_bad;
    logic [23:0]  status_lo;
    logic         unused_in;

    assign cmd_op    = arm_to_fpga_cmd[7:0];
    assign cmd_n     = arm_to_fpga_cmd[15:8];
    assign n_bad     = (cmd_n == 8'd0) || (cmd_n > 8'(DEPTH));
    assign unused_in = ^{arm_to_fpga_cmd[31:16], arm_to_fpga_data};

    always_comb begin
        state_d    = state_q;
        enc_auth_d = enc_auth_q;
        key_d      = key_q;
        iv_d       = iv_q;
        i_len_d    = i_len_q;
        tag_len_d  = tag_len_q;
        slot_d     = slot_q;
        result_d   = result_q;
        idx_d      = idx_q;
        n_d        = n_q;
        batch_n_d  = batch_n_q;
        op_d       = op_q;
        err_d      = err_q;
        core_init  = 1'b0;
        core_next  = 1'b0;
        core_final = 1'b0;
        core_blk   = slot_q[0];
        core_len   = i_len_q;
        case (state_q)
            ST_WAIT_CMD: if (arm_to_fpga_cmd_valid) begin
                err_d = 1'b0;
                op_d  = cmd_op[2:0];
                case (cmd_op)
                    OP_READ_CFG: state_d = ST_READ_CFG;
                    OP_READ_BLK: if (n_bad) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        n_d     = cmd_n[2:0];
                        state_d = ST_READ_BLK;
                    end
                    OP_INIT:     state_d = ST_INIT;
                    OP_BATCH: if (n_bad) begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        n_d       = cmd_n[2:0];
                        batch_n_d = cmd_n[2:0];
                        idx_d     = 3'd0;
                        state_d   = ST_ISSUE;
                    end
                    OP_FINAL:    state_d = ST_FINAL;
                    OP_WRITE:    state_d = ST_WRITE;
                    default: begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                endcase
            end
            ST_READ_CFG: if (arm_to_fpga_data_valid) begin
                enc_auth_d = arm_to_fpga_data[528];
                key_d      = arm_to_fpga_data[527:272];
                iv_d       = arm_to_fpga_data[271:144];
                i_len_d    = arm_to_fpga_data[15:8];
                tag_len_d  = arm_to_fpga_data[7:0];
                state_d    = ST_DONE;
            end
            ST_READ_BLK: if (arm_to_fpga_data_valid) begin
                for (int k = 0; k < DEPTH; k++)
                    if (3'(k) < n_q) slot_d[k] = arm_to_fpga_data[128*k +: 128];
                state_d = ST_DONE;
            end
            ST_INIT: if (core_ready) begin
                core_init = 1'b1;
                state_d   = ST_BUSY;
            end
            ST_ISSUE: begin
                for (int k = 0; k < DEPTH; k++)
                    if (idx_q == 3'(k)) core_blk = slot_q[k];
                core_len = 8'd128;
                if (core_ready) begin
                    core_next = 1'b1;
                    state_d   = ST_BUSY;
                end
            end
            ST_FINAL: if (core_ready) begin
                core_final = 1'b1;
                state_d    = ST_BUSY;
            end
            // op_q remembers which command put us here.
            ST_BUSY: if (core_ready) begin
                state_d = ST_DONE;
                if (op_q == OP_BATCH[2:0]) begin
                    for (int k = 0; k < DEPTH; k++)
                        if (idx_q == 3'(k)) result_d[k] = core_out;
                    idx_d = idx_q + 3'd1;
                    if (idx_q + 3'd1 != n_q) state_d = ST_ISSUE;
                end else if (op_q == OP_FINAL[2:0]) begin
                    result_d[0] = core_out;
                end
            end
            ST_WRITE: if (fpga_to_arm_data_ready) state_d = ST_DONE;
            ST_DONE:  if (fpga_to_arm_done_read) state_d = ST_WAIT_CMD;
            default:  state_d = ST_WAIT_CMD;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_WAIT_CMD;
            enc_auth_q  <= 1'b0;
            key_q       <= '0;
            iv_q        <= '0;
            i_len_q     <= '0;
            tag_len_q   <= '0;
            slot_q      <= '0;
            result_q    <= '0;
            idx_q       <= '0;
            n_q         <= '0;
            batch_n_q   <= '0;
            op_q        <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            enc_auth_q  <= enc_auth_d;
            key_q       <= key_d;
            iv_q        <= iv_d;
            i_len_q     <= i_len_d;
            tag_len_q   <= tag_len_d;
            slot_q      <= slot_d;
            result_q    <= result_d;
            idx_q       <= idx_d;
            n_q         <= n_d;
            batch_n_q   <= batch_n_d;
            op_q        <= op_d;
            err_q       <= err_d;
            done_q      <= (state_d == ST_DONE);
            in_ready_q  <= (state_d == ST_READ_CFG) || (state_d == ST_READ_BLK);
            out_valid_q <= (state_d == ST_WRITE);
        end
    end

`ifdef ZUC256_BATCH_CYCLE_CNT_EN
    logic [23:0] cyc_cnt_q, cyc_cnt_d;

    always_comb begin
        cyc_cnt_d = cyc_cnt_q;
        if (state_q == ST_WAIT_CMD &&
            (state_d == ST_INIT || state_d == ST_ISSUE || state_d == ST_FINAL))
            cyc_cnt_d = '0;
        else if ((state_q == ST_ISSUE || state_q == ST_BUSY) && cyc_cnt_q != 24'hFFFFFF)
            cyc_cnt_d = cyc_cnt_q + 24'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) cyc_cnt_q <= '0;
        else         cyc_cnt_q <= cyc_cnt_d;
    end

    assign status_lo = cyc_cnt_q;
`else
    assign status_lo = '0;
`endif

    always_comb begin
        fpga_to_arm_data = '0;
        for (int k = 0; k < DEPTH; k++)
            fpga_to_arm_data[128*k +: 128] = result_q[k];
        fpga_to_arm_data[BUS_W-1 -: 32] = {err_q, 4'd0, batch_n_q, status_lo};
    end

    assign fpga_to_arm_done       = done_q;
    assign arm_to_fpga_data_ready = in_ready_q;
    assign fpga_to_arm_data_valid = out_valid_q;
    assign leds                   = state_q;

    zuc256_tot u_core (
        .clk     (clk),
        .resetn  (resetn),
        .init    (core_init),
        .next    (core_next),
        .fin     (core_final),
        .enc_auth(enc_auth_q),
        .key     (key_q),
        .iv      (iv_q),
        .block_i (core_blk),
        .i_len   (core_len),
        .tag_len (tag_len_q),
        .block_o (core_out),
        .ready   (core_ready)
    );
endmodule

// File: doc/zuc256_batch_wrapper.md
ZUC256_BATCH_WRAPPER -- requirements
Module: zuc256_batch_wrapper

Interface
REQ-001 Parameter BUS_W, default 1024: width of both ARM data buses.
REQ-002 Parameter DEPTH, default 4, legal 1..7: number of 128-bit block slots; elaboration SHALL fail unless BUS_W >= 128*DEPTH+32 and BUS_W >= 529.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 arm_to_fpga_cmd  in  32  command; [7:0] opcode, [15:8] block count N.
REQ-006 arm_to_fpga_cmd_valid  in  1  command strobe, sampled only in WAIT_CMD.
REQ-007 fpga_to_arm_done  out  1  command complete.
REQ-008 fpga_to_arm_done_read  in  1  ARM acknowledges done.
REQ-009 arm_to_fpga_data_valid  in  1; arm_to_fpga_data_ready  out  1; arm_to_fpga_data  in  BUS_W.
REQ-010 fpga_to_arm_data_valid  out  1; fpga_to_arm_data_ready  in  1; fpga_to_arm_data  out  BUS_W.
REQ-011 leds  out  4  current FSM state encoding.
REQ-012 One zuc256_tot instance SHALL be driven: init/next/final single-cycle pulses, enc_auth, key, iv, block_i, i_len, tag_len; block_o and ready returned.

Function
REQ-013 Opcodes: 0 READ_CFG, 1 READ_BLK, 2 INIT, 3 BATCH, 4 FINAL, 5 WRITE; any other opcode, or BATCH/READ_BLK with N=0 or N>DEPTH, SHALL go directly to DONE with err flag set and no data or core activity.
REQ-014 Any accepted valid command SHALL clear err.
REQ-015 States: WAIT_CMD, READ_CFG, READ_BLK, INIT, ISSUE, BUSY, FINAL, WRITE, DONE.
REQ-016 READ_CFG: on data_valid capture enc_auth=[528], key=[527:272], iv=[271:144], i_len=[15:8], tag_len=[7:0]; go to DONE.
REQ-017 READ_BLK: on data_valid capture slots 0..N-1 from [128k+127:128k]; slots >= N unchanged; go to DONE.
REQ-018 arm_to_fpga_data_ready SHALL be registered, high exactly the cycles after the FSM is in READ_CFG/READ_BLK; fpga_to_arm_data_valid likewise for WRITE; fpga_to_arm_done likewise for DONE.
REQ-019 INIT: pulse core init one cycle, enter BUSY; on ready go to DONE, no result stored.
REQ-020 BATCH: index idx=0; ISSUE pulses core next with block_i=slot[idx], i_len=8'd128; BUSY waits for ready, writes block_o to result[idx], increments idx; if idx==N go to DONE else back to ISSUE.
REQ-021 FINAL: pulse core final with block_i=slot 0 and captured i_len; on ready store block_o to result[0]; go to DONE.
REQ-022 WRITE: fpga_to_arm_data = result k at [128k+127:128k], status word at [BUS_W-1:BUS_W-32], zeros elsewhere; on data_ready go to DONE.
REQ-023 Status word: [31] err, [30:24] last batch count N, [23:0] per REQ-029.
REQ-024 DONE: on done_read return to WAIT_CMD; done SHALL stay high until then.
REQ-025 Core strobes SHALL never be issued while the core is busy; minimum gap between successive next pulses in BATCH is 2 cycles.
REQ-026 Input and result registers SHALL not change outside the states above.

Reset
REQ-027 On resetn low, immediately: FSM=WAIT_CMD, all config, slot, result, idx, err, counter registers zero; done, data_ready, data_valid low; core strobes low. Reset mid-batch SHALL abandon the batch with no further core pulses.

Configuration
REQ-028 Macro ZUC256_BATCH_CYCLE_CNT_EN selects the busy-cycle counter.
REQ-029 Defined: a 24-bit counter clears on each accepted INIT/BATCH/FINAL, increments every cycle in ISSUE or BUSY, saturates at 24'hFFFFFF, and appears in status [23:0]. Undefined: counter absent, status [23:0] reads zero.

Verification
REQ-030 Reset mid-BATCH (idx=2, N=4) -> outputs low, state WAIT_CMD, leds=0, no further next pulses.
REQ-031 READ_CFG then INIT then READ_BLK N=4 then BATCH N=4 then WRITE -> exactly 4 next pulses, four results match golden model in slot order, status[30:24]=4, err=0.
REQ-032 BATCH N=0 and opcode 9 -> done asserted within 2 cycles, err=1, zero core pulses.
REQ-033 READ_BLK N=2 after N=4 load -> slots 2,3 retain prior values; BATCH N=4 results match.
REQ-034 WRITE with data_ready held low 10 cycles -> data_valid stays high, data stable, done only after ready.
REQ-035 With ZUC256_BATCH_CYCLE_CNT_EN defined, BATCH N=1 -> status[23:0] equals ISSUE+BUSY cycle count; undefined -> 0.
